periph_master: RTL and testbench

Initiator side of the peripheral bus. It accepts single load/store requests from the core's memory stage and turns each one into one peripheral-bus transaction: it drives address, select, strobes and write data, then holds them until the responder asserts ready. It returns read data or an error to the core. It sits between the core's data-memory path and the peripheral bus decoder, with the decoder's `i_*` bus inputs fed from this block's `o_*` bus outputs.

---
 rtl/periph_master.sv | 152 +++++++++++++++
 tb/tb_periph_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/periph_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | periph_master                                                            |
// | Peripheral-bus initiator: one core load/store becomes one bus access.    |
// | Optional ready timeout enabled by defining PERIPH_MASTER_TIMEOUT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module periph_master #(
    parameter logic [3:0]  PERIPH_BASE    = 4'hF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [15:0] o_addr,
    output logic        o_sel,
    output logic        o_we,
    output logic        o_re,
    output logic [15:0] o_wdata,
    input  logic [15:0] i_rdata,
    input  logic        i_rdy
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_err;
    logic [15:0] w_rdata_next;
    logic        w_err_next;
    logic        w_accept;
    logic        w_in_window;
    logic        w_timeout;

    // A zero timeout would leave ACCESS with no legal length.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    end

    assign w_accept    = (r_state == c_idle) && i_req_valid;
    assign w_in_window = (i_req_addr[15:12] == PERIPH_BASE);

`ifdef PERIPH_MASTER_TIMEOUT_EN
    localparam int unsigned c_cnt_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_max  = c_cnt_width'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_width-1:0] c_cnt_one  = c_cnt_width'(1);

    logic [c_cnt_width-1:0] r_cnt;

    // Counter is zero on every ACCESS entry because it is cleared outside ACCESS.
    always_ff @(posedge i_clk) begin
        if (!i_rst || (r_state != c_access)) begin
            r_cnt <= '0;
        end else if (!i_rdy && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Fires on the last counted cycle; ready on that same cycle takes priority.
    assign w_timeout = (r_state == c_access) && (r_cnt == c_cnt_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= c_idle;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_sel        = 1'b0;
        o_we         = 1'b0;
        o_re         = 1'b0;
        o_addr       = '0;
        o_wdata      = '0;
        case (r_state)
            c_idle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_in_window) begin
                        w_state_next = c_access;
                    end else begin
                        w_state_next = c_resp;
                        w_rdata_next = '0;
                        w_err_next   = 1'b1;
                    end
                end
            end
            c_access: begin
                o_sel   = 1'b1;
                o_we    = r_we;
                o_re    = !r_we;
                o_addr  = r_addr;
                o_wdata = r_wdata;
                if (i_rdy) begin
                    w_state_next = c_resp;
                    w_rdata_next = r_we ? 16'h0000 : i_rdata;
                    w_err_next   = 1'b0;
                end else if (w_timeout) begin
                    w_state_next = c_resp;
                    w_rdata_next = '0;
                    w_err_next   = 1'b1;
                end
            end
            c_resp: begin
                o_rsp_valid  = 1'b1;
                w_state_next = c_idle;
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_periph_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_periph_master                                                         |
// | Directed and randomized transactions against a transaction-level model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_periph_master;

    localparam int unsigned c_timeout = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] bus_addr;
    logic        bus_sel;
    logic        bus_we;
    logic        bus_re;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_rdy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int prev_acc = 0;

    periph_master #(
        .PERIPH_BASE    (4'hF),
        .TIMEOUT_CYCLES (c_timeout)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_req_valid (req_valid),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_addr      (bus_addr),
        .o_sel       (bus_sel),
        .o_we        (bus_we),
        .o_re        (bus_re),
        .o_wdata     (bus_wdata),
        .i_rdata     (bus_rdata),
        .i_rdy       (bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of cycles the bus is held for a request that is ready after `waits` idle cycles.
    function automatic int bus_cycles(input logic [15:0] addr, input int waits);
        if (addr[15:12] != 4'hF) return 0;
`ifdef PERIPH_MASTER_TIMEOUT_EN
        if (waits >= int'(c_timeout)) return int'(c_timeout);
`endif
        return waits + 1;
    endfunction

    // Called at a negedge; returns at the negedge of the first IDLE cycle after the response.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] rdata, input int waits, input bit keep,
                       input bit chk_gap);
        int  exp_bus;
        bit  exp_err;
        logic [15:0] exp_rdata;
        int  sel_cnt;
        int  acc;
        bit  got;
        exp_bus   = bus_cycles(addr, waits);
        exp_err   = (exp_bus == 0) || (exp_bus < waits + 1);
        exp_rdata = (exp_err || we) ? 16'h0000 : rdata;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
        if (!req_ready) begin
            chk("accept_wait", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (chk_gap) chk("b2b_gap", 32'(acc - prev_acc), 32'd3);
        prev_acc = acc;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        sel_cnt = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (bus_sel) begin
                sel_cnt++;
                chk("bus_addr", 32'(bus_addr), 32'(addr));
                chk("bus_wdata", 32'(bus_wdata), 32'(wdata));
                chk("bus_we", 32'(bus_we), 32'(we));
                chk("bus_re", 32'(bus_re), 32'(!we));
                bus_rdy   = (sel_cnt == waits + 1);
                bus_rdata = bus_rdy ? rdata : 16'($urandom);
            end else begin
                chk("bus_idle", {bus_we, bus_re, bus_addr, 14'(0)} | 32'(bus_wdata), 32'd0);
                bus_rdy = 1'b0;
            end
            if (rsp_valid) begin
                chk("rsp_latency", 32'(k), 32'(exp_bus + 1));
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                chk("sel_cycles", 32'(sel_cnt), 32'(exp_bus));
                got = 1'b1;
                break;
            end
        end
        bus_rdy = 1'b0;
        if (!got) chk("rsp_missing", 32'(got), 32'd1);
        @(negedge clk);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("rsp_single", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int waits;
        logic [15:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bus_rdata = '0;
        bus_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", {rsp_valid, rsp_err, bus_sel, bus_we, bus_re, 27'(0)}, 32'd0);
        chk("rst_data", {bus_addr, bus_wdata} | 32'(rsp_rdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 16'hF200, 16'h000A, 16'h0000, 0, 1'b0, 1'b0);
        txn(1'b0, 16'hF304, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0);
        txn(1'b0, 16'h1234, 16'h0000, 16'h5555, 0, 1'b0, 1'b0);
`ifdef PERIPH_MASTER_TIMEOUT_EN
        txn(1'b0, 16'hF010, 16'h0000, 16'hAAAA, 10, 1'b0, 1'b0);
        txn(1'b1, 16'hF012, 16'h1357, 16'h0000, 10, 1'b0, 1'b0);
        txn(1'b0, 16'hF014, 16'h0000, 16'hC0DE, 3, 1'b0, 1'b0);
`else
        txn(1'b0, 16'hF010, 16'h0000, 16'hAAAA, 10, 1'b0, 1'b0);
`endif

        // Reset during the first ACCESS cycle.
        req_we    = 1'b0;
        req_addr  = 16'hF0F0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_sel", 32'(bus_sel), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus", {bus_sel, bus_we, bus_re, bus_addr, 13'(0)}, 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        txn(1'b0, 16'hF0F0, 16'h0000, 16'h4321, 1, 1'b0, 1'b0);

        txn(1'b1, 16'hF100, 16'h0001, 16'h0000, 0, 1'b1, 1'b0);
        txn(1'b1, 16'hF102, 16'h0002, 16'h0000, 0, 1'b1, 1'b1);
        txn(1'b1, 16'hF104, 16'h0003, 16'h0000, 0, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[15:12] = 4'hF;
            else a[15:12] = 4'($urandom_range(0, 14));
            waits = int'($urandom_range(0, 6));
            txn(1'($urandom), a, 16'($urandom), 16'($urandom), waits,
                (i < 23) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
